// File: rtl/world_clock_scheduler.sv
// ----------------------------------------------------------------------------
// world_clock_scheduler
//
// Picks one of eight world-clock zones and presents that zone's hour as two
// BCD digits. Zone selection comes from the crown sector (MANUAL), from an
// automatic tour that steps one zone every TOUR_SEC seconds (TOUR), or from
// the crown during a tour interruption that resumes touring after HOLD_SEC
// quiet seconds (HOLD).
//
// Ports
//   clk               in   system clock, rising-edge
//   rst               in   synchronous active-high reset
//   En                in   multi-clock mode enable
//   tick_1hz          in   one-clk pulse per second
//   auto_en           in   auto-tour request level
//   hour              in   local (Seoul) hour, 0..23 (24..31 folded by -24)
//   DigitalCrownValue in   crown position, sector = bits [9:7]
//   zone              out  selected zone index (registered)
//   hour_10, hour_1   out  BCD tens/units of the zone hour (registered)
//   zone_chg          out  one-cycle pulse while zone shows a new value
//   tour_active       out  high while the FSM is in TOUR
// ----------------------------------------------------------------------------
module world_clock_scheduler #(
    parameter int TOUR_SEC = 3,
    parameter int HOLD_SEC = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       En,
    input  logic       tick_1hz,
    input  logic       auto_en,
    input  logic [4:0] hour,
    input  logic [9:0] DigitalCrownValue,
    output logic [2:0] zone,
    output logic [3:0] hour_10,
    output logic [3:0] hour_1,
    output logic       zone_chg,
    output logic       tour_active
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        TOUR   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] TOUR_LAST = 4'(TOUR_SEC - 1);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_SEC - 1);

    // Offset of each zone relative to Seoul, already reduced mod 24.
    function automatic logic [4:0] zone_offset(input logic [2:0] z);
        logic [4:0] off;
        case (z)
            3'd0:    off = 5'd0;
            3'd1:    off = 5'd23;
            3'd2:    off = 5'd18;
            3'd3:    off = 5'd16;
            3'd4:    off = 5'd15;
            3'd5:    off = 5'd10;
            3'd6:    off = 5'd7;
            3'd7:    off = 5'd2;
            default: off = 5'd0;
        endcase
        return off;
    endfunction

    // Zone hour as {tens, units}; 6-bit sum so hour+offset never overflows.
    function automatic logic [7:0] zone_digits(input logic [2:0] z, input logic [4:0] h);
        logic [5:0] base;
        logic [5:0] sum;
        logic [3:0] tens;
        logic [3:0] units;
        if (h >= 5'd24) begin
            base = {1'b0, h - 5'd24};
        end else begin
            base = {1'b0, h};
        end
        sum = base + {1'b0, zone_offset(z)};
        if (sum >= 6'd24) begin
            sum = sum - 6'd24;
        end else begin
            sum = sum;
        end
        if (sum >= 6'd20) begin
            tens  = 4'd2;
            units = 4'(sum - 6'd20);
        end else if (sum >= 6'd10) begin
            tens  = 4'd1;
            units = 4'(sum - 6'd10);
        end else begin
            tens  = 4'd0;
            units = 4'(sum);
        end
        return {tens, units};
    endfunction

    state_t     state_q, state_d;
    logic [2:0] zone_q, zone_d;
    logic [2:0] last_sector_q;
    logic [3:0] sec_cnt_q, sec_cnt_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] hour_10_q, hour_1_q;
    logic       zone_chg_q;
    logic       tour_active_q;

    logic [2:0] sector_s;
    logic       crown_chg_s;
    logic [7:0] digits_s;

    assign sector_s    = DigitalCrownValue[9:7];
    assign crown_chg_s = (sector_s != last_sector_q);
    // Digits follow the zone register, so they trail a zone change by one clk.
    assign digits_s    = zone_digits(zone_q, hour);

    // Next-state logic; branch order encodes En > auto_en > crown > tick.
    always_comb begin
        state_d    = state_q;
        zone_d     = zone_q;
        sec_cnt_d  = sec_cnt_q;
        hold_cnt_d = hold_cnt_q;
        if (!En) begin
            state_d    = IDLE;
            zone_d     = 3'd0;
            sec_cnt_d  = 4'd0;
            hold_cnt_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    zone_d     = 3'd0;
                    sec_cnt_d  = 4'd0;
                    hold_cnt_d = 4'd0;
                    state_d    = auto_en ? TOUR : MANUAL;
                end
                MANUAL: begin
                    if (auto_en) begin
                        // Tour starts from whatever zone is currently shown.
                        state_d   = TOUR;
                        sec_cnt_d = 4'd0;
                    end else begin
                        zone_d = sector_s;
                    end
                end
                TOUR: begin
                    if (!auto_en) begin
                        state_d    = MANUAL;
                        sec_cnt_d  = 4'd0;
                        hold_cnt_d = 4'd0;
                    end else if (crown_chg_s) begin
                        // Crown beats a coincident advance tick.
                        state_d    = HOLD;
                        zone_d     = sector_s;
                        sec_cnt_d  = 4'd0;
                        hold_cnt_d = 4'd0;
                    end else if (tick_1hz) begin
                        if (sec_cnt_q >= TOUR_LAST) begin
                            zone_d    = zone_q + 3'd1;
                            sec_cnt_d = 4'd0;
                        end else begin
                            sec_cnt_d = sec_cnt_q + 4'd1;
                        end
                    end else begin
                        sec_cnt_d = sec_cnt_q;
                    end
                end
                HOLD: begin
                    if (!auto_en) begin
                        state_d    = MANUAL;
                        sec_cnt_d  = 4'd0;
                        hold_cnt_d = 4'd0;
                    end else begin
                        zone_d = sector_s;
                        if (crown_chg_s) begin
                            hold_cnt_d = 4'd0;
                        end else if (tick_1hz) begin
                            if (hold_cnt_q >= HOLD_LAST) begin
                                state_d    = TOUR;
                                sec_cnt_d  = 4'd0;
                                hold_cnt_d = 4'd0;
                            end else begin
                                hold_cnt_d = hold_cnt_q + 4'd1;
                            end
                        end else begin
                            hold_cnt_d = hold_cnt_q;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    zone_d     = 3'd0;
                    sec_cnt_d  = 4'd0;
                    hold_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // State, counters and all outputs registered; crown sector sampled every clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            zone_q        <= 3'd0;
            last_sector_q <= 3'd0;
            sec_cnt_q     <= 4'd0;
            hold_cnt_q    <= 4'd0;
            hour_10_q     <= 4'd0;
            hour_1_q      <= 4'd0;
            zone_chg_q    <= 1'b0;
            tour_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            zone_q        <= zone_d;
            last_sector_q <= sector_s;
            sec_cnt_q     <= sec_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            hour_10_q     <= digits_s[7:4];
            hour_1_q      <= digits_s[3:0];
            // High during the first cycle the new zone value is visible.
            zone_chg_q    <= (zone_d != zone_q);
            tour_active_q <= (state_d == TOUR);
        end
    end

    assign zone        = zone_q;
    assign hour_10     = hour_10_q;
    assign hour_1      = hour_1_q;
    assign zone_chg    = zone_chg_q;
    assign tour_active = tour_active_q;

endmodule

// File: tb/tb_world_clock_scheduler.sv
// ----------------------------------------------------------------------------
// tb_world_clock_scheduler
//
// Scenario tasks drive one row per clock; each row pushes its expected
// {zone, hour_10, hour_1, zone_chg, tour_active} to a scoreboard queue,
// which is popped and compared after the clock edge.
// ----------------------------------------------------------------------------
module tb_world_clock_scheduler;

    logic       clk;
    logic       rst;
    logic       En;
    logic       tick_1hz;
    logic       auto_en;
    logic [4:0] hour;
    logic [9:0] DigitalCrownValue;
    logic [2:0] zone;
    logic [3:0] hour_10;
    logic [3:0] hour_1;
    logic       zone_chg;
    logic       tour_active;

    int checks = 0;
    int errors = 0;
    logic [12:0] sb[$];

    typedef struct {
        logic        rs;
        logic        en;
        logic        aut;
        logic        tk;
        logic [9:0]  crown;
        logic [4:0]  hr;
        logic [12:0] exp;
    } row_t;

    world_clock_scheduler #(.TOUR_SEC(3), .HOLD_SEC(5)) dut (
        .clk(clk),
        .rst(rst),
        .En(En),
        .tick_1hz(tick_1hz),
        .auto_en(auto_en),
        .hour(hour),
        .DigitalCrownValue(DigitalCrownValue),
        .zone(zone),
        .hour_10(hour_10),
        .hour_1(hour_1),
        .zone_chg(zone_chg),
        .tour_active(tour_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference zone hour as {tens, units}, computed from a table of offsets.
    function automatic logic [7:0] zh(input int z, input int hr);
        int off[8];
        int v;
        off = '{0, 23, 18, 16, 15, 10, 7, 2};
        v = ((hr % 24) + off[z]) % 24;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Expected output vector: shown zone z, digits from zone dz at hour hr.
    function automatic logic [12:0] mk(input int z, input int dz, input int hr,
                                       input logic chg, input logic ta);
        logic [7:0] d;
        d = zh(dz, hr);
        return {3'(z), d, chg, ta};
    endfunction

    function automatic logic [12:0] observed();
        return {zone, hour_10, hour_1, zone_chg, tour_active};
    endfunction

    task automatic apply(input row_t r);
        rst               = r.rs;
        En                = r.en;
        auto_en           = r.aut;
        tick_1hz          = r.tk;
        DigitalCrownValue = r.crown;
        hour              = r.hr;
        sb.push_back(r.exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; En = 1'b0; auto_en = 1'b0; tick_1hz = 1'b0;
        DigitalCrownValue = 10'd0; hour = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        row_t rows[2];
        logic [12:0] e, g;
        rows = '{'{1'b1, 1'b1, 1'b1, 1'b1, 10'd1023, 5'd31, 13'd0},
                 '{1'b1, 1'b1, 1'b1, 1'b1, 10'd1023, 5'd31, 13'd0}};
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); g = observed(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got z/h10/h1/chg/act=%0d/%0d/%0d/%0b/%0b expected %0d/%0d/%0d/%0b/%0b",
                         i, g[12:10], g[9:6], g[5:2], g[1], g[0], e[12:10], e[9:6], e[5:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_manual();
        row_t rows[5];
        logic [12:0] e, g;
        do_reset();
        rows = '{'{1'b0, 1'b1, 1'b0, 1'b0, 10'd300, 5'd9,  mk(0, 0, 9, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b0, 1'b0, 10'd300, 5'd9,  mk(2, 0, 9, 1'b1, 1'b0)},
                 '{1'b0, 1'b1, 1'b0, 1'b0, 10'd300, 5'd9,  mk(2, 2, 9, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b0, 1'b0, 10'd896, 5'd23, mk(7, 2, 23, 1'b1, 1'b0)},
                 '{1'b0, 1'b1, 1'b0, 1'b0, 10'd896, 5'd23, mk(7, 7, 23, 1'b0, 1'b0)}};
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            tick_1hz = 1'b0;
            e = sb.pop_front(); g = observed(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL manual[%0d]: got z/h10/h1/chg/act=%0d/%0d/%0d/%0b/%0b expected %0d/%0d/%0d/%0b/%0b",
                         i, g[12:10], g[9:6], g[5:2], g[1], g[0], e[12:10], e[9:6], e[5:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_tour();
        row_t rows[12];
        logic [12:0] e, g;
        do_reset();
        rows = '{'{1'b0, 1'b1, 1'b0, 1'b0, 10'd896, 5'd23, mk(0, 0, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b0, 1'b0, 10'd896, 5'd23, mk(7, 0, 23, 1'b1, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b0, 10'd896, 5'd23, mk(7, 7, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd896, 5'd23, mk(7, 7, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b0, 10'd896, 5'd23, mk(7, 7, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd896, 5'd23, mk(7, 7, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd896, 5'd23, mk(0, 7, 23, 1'b1, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b0, 10'd896, 5'd23, mk(0, 0, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd896, 5'd23, mk(0, 0, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd896, 5'd23, mk(0, 0, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd896, 5'd23, mk(1, 0, 23, 1'b1, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b0, 10'd896, 5'd23, mk(1, 1, 23, 1'b0, 1'b1)}};
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            tick_1hz = 1'b0;
            e = sb.pop_front(); g = observed(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL tour[%0d]: got z/h10/h1/chg/act=%0d/%0d/%0d/%0b/%0b expected %0d/%0d/%0d/%0b/%0b",
                         i, g[12:10], g[9:6], g[5:2], g[1], g[0], e[12:10], e[9:6], e[5:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_hold();
        row_t rows[14];
        logic [12:0] e, g;
        do_reset();
        rows = '{'{1'b0, 1'b1, 1'b1, 1'b0, 10'd0,   5'd23, mk(0, 0, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd0,   5'd23, mk(0, 0, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd0,   5'd23, mk(0, 0, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd640, 5'd23, mk(5, 0, 23, 1'b1, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b0, 10'd640, 5'd23, mk(5, 5, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd640, 5'd23, mk(5, 5, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd640, 5'd23, mk(5, 5, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd640, 5'd23, mk(5, 5, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd640, 5'd23, mk(5, 5, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd640, 5'd23, mk(5, 5, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd640, 5'd23, mk(5, 5, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd640, 5'd23, mk(5, 5, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd640, 5'd23, mk(6, 5, 23, 1'b1, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b0, 10'd640, 5'd23, mk(6, 6, 23, 1'b0, 1'b1)}};
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            tick_1hz = 1'b0;
            e = sb.pop_front(); g = observed(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL hold[%0d]: got z/h10/h1/chg/act=%0d/%0d/%0d/%0b/%0b expected %0d/%0d/%0d/%0b/%0b",
                         i, g[12:10], g[9:6], g[5:2], g[1], g[0], e[12:10], e[9:6], e[5:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_hold_restart();
        row_t rows[11];
        logic [12:0] e, g;
        do_reset();
        rows = '{'{1'b0, 1'b1, 1'b1, 1'b0, 10'd0,   5'd23, mk(0, 0, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b0, 10'd640, 5'd23, mk(5, 0, 23, 1'b1, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd640, 5'd23, mk(5, 5, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd640, 5'd23, mk(5, 5, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd640, 5'd23, mk(5, 5, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd384, 5'd23, mk(3, 5, 23, 1'b1, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd384, 5'd23, mk(3, 3, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd384, 5'd23, mk(3, 3, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd384, 5'd23, mk(3, 3, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd384, 5'd23, mk(3, 3, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd384, 5'd23, mk(3, 3, 23, 1'b0, 1'b1)}};
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            tick_1hz = 1'b0;
            e = sb.pop_front(); g = observed(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL hold_restart[%0d]: got z/h10/h1/chg/act=%0d/%0d/%0d/%0b/%0b expected %0d/%0d/%0d/%0b/%0b",
                         i, g[12:10], g[9:6], g[5:2], g[1], g[0], e[12:10], e[9:6], e[5:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_disable();
        row_t rows[10];
        logic [12:0] e, g;
        do_reset();
        rows = '{'{1'b0, 1'b1, 1'b0, 1'b0, 10'd512, 5'd23, mk(0, 0, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b0, 1'b0, 10'd512, 5'd23, mk(4, 0, 23, 1'b1, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b0, 10'd512, 5'd23, mk(4, 4, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b0, 1'b1, 1'b0, 10'd512, 5'd23, mk(0, 4, 23, 1'b1, 1'b0)},
                 '{1'b0, 1'b0, 1'b1, 1'b0, 10'd512, 5'd23, mk(0, 0, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b0, 1'b1, 1'b0, 10'd512, 5'd24, mk(0, 0, 24, 1'b0, 1'b0)},
                 '{1'b0, 1'b0, 1'b1, 1'b0, 10'd512, 5'd31, mk(0, 0, 31, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b1, 1'b0, 10'd512, 5'd23, mk(0, 0, 23, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b0, 1'b0, 10'd512, 5'd23, mk(0, 0, 23, 1'b0, 1'b0)},
                 '{1'b0, 1'b1, 1'b0, 1'b0, 10'd512, 5'd23, mk(4, 0, 23, 1'b1, 1'b0)}};
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            tick_1hz = 1'b0;
            e = sb.pop_front(); g = observed(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL disable[%0d]: got z/h10/h1/chg/act=%0d/%0d/%0d/%0b/%0b expected %0d/%0d/%0d/%0b/%0b",
                         i, g[12:10], g[9:6], g[5:2], g[1], g[0], e[12:10], e[9:6], e[5:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[8];
        logic [12:0] e, g;
        do_reset();
        rows = '{'{1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 5'd9, mk(0, 0, 9, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 5'd9, mk(0, 0, 9, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 5'd9, mk(0, 0, 9, 1'b0, 1'b1)},
                 '{1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 5'd9, 13'd0},
                 '{1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 5'd9, mk(0, 0, 9, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 5'd9, mk(0, 0, 9, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 5'd9, mk(0, 0, 9, 1'b0, 1'b1)},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 5'd9, mk(1, 0, 9, 1'b1, 1'b1)}};
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            tick_1hz = 1'b0;
            e = sb.pop_front(); g = observed(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got z/h10/h1/chg/act=%0d/%0d/%0d/%0b/%0b expected %0d/%0d/%0d/%0b/%0b",
                         i, g[12:10], g[9:6], g[5:2], g[1], g[0], e[12:10], e[9:6], e[5:2], e[1], e[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; En = 1'b0; auto_en = 1'b0; tick_1hz = 1'b0;
        DigitalCrownValue = 10'd0; hour = 5'd0;
        test_reset();
        test_manual();
        test_tour();
        test_hold();
        test_hold_restart();
        test_disable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
